// File: rtl/alu_seq_muldiv.sv
// Handshaked execute-stage ALU: single-cycle logic/arith ops plus iterative
// signed/unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  input  logic             Sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Z_hi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivZero
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011,
                         OP_AND = 3'b100, OP_OR  = 3'b101, OP_XOR = 3'b110, OP_SLT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div, r_neg_a, r_neg_b, r_bzero, r_minovf;
  logic [WIDTH-1:0] r_a, r_opnd, r_hi, r_lo;

  logic [WIDTH:0]   w_sum, w_diff, w_mul_sum, w_div_sh;
  logic [WIDTH-1:0] w_z, w_abs_a, w_abs_b, w_div_sub, w_fix_z, w_fix_hi;
  logic [2*WIDTH-1:0] w_prod_n;
  logic             w_ovf, w_div_ge, w_neg_a, w_neg_b, w_fix_ovf, w_fix_dz;

  assign w_sum   = {1'b0, A} + {1'b0, B};
  assign w_diff  = {1'b0, A} - {1'b0, B};
  assign w_neg_a = Sign & A[WIDTH-1];
  assign w_neg_b = Sign & B[WIDTH-1];
  assign w_abs_a = w_neg_a ? -A : A;
  assign w_abs_b = w_neg_b ? -B : B;

  always_comb begin
    w_z   = '0;
    w_ovf = 1'b0;
    case (Op)
      OP_ADD: begin
        w_z   = w_sum[WIDTH-1:0];
        w_ovf = Sign ? ((A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1])) : w_sum[WIDTH];
      end
      OP_SUB: begin
        w_z   = w_diff[WIDTH-1:0];
        w_ovf = Sign ? ((A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1])) : w_diff[WIDTH];
      end
      OP_AND: w_z = A & B;
      OP_OR:  w_z = A | B;
      OP_XOR: w_z = A ^ B;
      OP_SLT: w_z = {{(WIDTH-1){1'b0}}, Sign ? ($signed(A) < $signed(B)) : (A < B)};
      default: ;
    endcase
  end

  // MUL: r_hi accumulates, r_lo holds the multiplier shifting out / product low half.
  // DIV: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge  = w_div_sh >= {1'b0, r_opnd};
  assign w_div_sub = w_div_sh[WIDTH-1:0] - r_opnd;
  assign w_prod_n  = -{r_hi, r_lo};

  always_comb begin
    w_fix_z   = r_lo;
    w_fix_hi  = r_hi;
    w_fix_ovf = 1'b0;
    w_fix_dz  = 1'b0;
    if (!r_is_div) begin
      if (r_neg_a ^ r_neg_b) {w_fix_hi, w_fix_z} = w_prod_n;
    end else if (r_bzero) begin
      w_fix_z  = '1;
      w_fix_hi = r_a;
      w_fix_dz = 1'b1;
    end else begin
      if (r_neg_a ^ r_neg_b) w_fix_z = -r_lo;
      if (r_neg_a) w_fix_hi = -r_hi;
      w_fix_ovf = r_minovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_bzero   <= 1'b0;
      r_minovf  <= 1'b0;
      r_a       <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Z         <= '0;
      Z_hi      <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      DivZero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (Op == OP_MUL || Op == OP_DIV) begin
            r_state  <= S_CALC;
            r_cnt    <= '0;
            r_is_div <= (Op == OP_DIV);
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_bzero  <= (B == '0);
            r_minovf <= Sign && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
            r_a      <= A;
            r_opnd   <= (Op == OP_DIV) ? w_abs_b : w_abs_a;
            r_lo     <= (Op == OP_DIV) ? w_abs_a : w_abs_b;
            r_hi     <= '0;
          end else begin
            r_state   <= S_DONE;
            out_valid <= 1'b1;
            Z         <= w_z;
            Z_hi      <= '0;
            Zero      <= (w_z == '0);
            Overflow  <= w_ovf;
            DivZero   <= 1'b0;
          end
        end
        S_CALC: begin
          if (r_is_div) begin
            r_hi <= w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
          end else begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state   <= S_DONE;
          out_valid <= 1'b1;
          Z         <= w_fix_z;
          Z_hi      <= w_fix_hi;
          Zero      <= (w_fix_z == '0);
          Overflow  <= w_fix_ovf;
          DivZero   <= w_fix_dz;
        end
        S_DONE: if (out_ready) begin
          r_state   <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed-vector bench for alu_seq_muldiv (WIDTH=32) with hand-computed results,
// latency, backpressure and mid-operation reset checks.
module tb_alu_seq_muldiv;
  localparam int W = 32;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DIV = 3'b011,
                         AND_ = 3'b100, OR_ = 3'b101, XOR_ = 3'b110, SLT = 3'b111;

  logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready, Sign = 1'b0;
  logic         out_valid, out_ready = 1'b0, Zero, Overflow, DivZero;
  logic [W-1:0] A = '0, B = '0, Z, Z_hi;
  logic [2:0]   Op = '0;
  int           n_chk = 0, n_err = 0;

  alu_seq_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op), .Sign(Sign), .out_valid(out_valid), .out_ready(out_ready),
    .Z(Z), .Z_hi(Z_hi), .Zero(Zero), .Overflow(Overflow), .DivZero(DivZero));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, wait for the result, check it, then consume it.
  // lat = clock edges after the accept edge until out_valid is seen.
  task automatic run(input string tag, input logic [2:0] op, input logic sg,
                     input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                     input logic [W-1:0] ez, input logic [W-1:0] ehi,
                     input logic eovf, input logic edz);
    int n;
    n = 0;
    chk({tag, ".rdy"}, in_ready, 1'b1);
    A = a; B = b; Op = op; Sign = sg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".z"}, Z, ez);
    chk({tag, ".hi"}, Z_hi, ehi);
    chk({tag, ".zero"}, Zero, (ez == '0));
    chk({tag, ".ovf"}, Overflow, eovf);
    chk({tag, ".dz"}, DivZero, edz);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drop"}, out_valid, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.z", Z, '0);
    chk("rst.hi", Z_hi, '0);
    chk("rst.flags", {Zero, Overflow, DivZero}, 3'b000);
    reset = 1'b0;
    @(posedge clk); #1;

    // single-cycle group: result visible right after the accept edge
    run("add_s_ovf", ADD, 1'b1, 32'h7FFF_FFFF, 32'h1,         0, 32'h8000_0000, '0, 1'b1, 1'b0);
    run("add_u_cy",  ADD, 1'b0, 32'hFFFF_FFFF, 32'h1,         0, 32'h0,         '0, 1'b1, 1'b0);
    run("add_s_ok",  ADD, 1'b1, 32'h0000_0005, 32'hFFFF_FFFE, 0, 32'h3,         '0, 1'b0, 1'b0);
    run("sub_s_ovf", SUB, 1'b1, 32'h8000_0000, 32'h1,         0, 32'h7FFF_FFFF, '0, 1'b1, 1'b0);
    run("sub_u_bw",  SUB, 1'b0, 32'h0,         32'h1,         0, 32'hFFFF_FFFF, '0, 1'b1, 1'b0);
    run("and",  AND_, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hF000_F000, '0, 1'b0, 1'b0);
    run("or",   OR_,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hFFF0_FFF0, '0, 1'b0, 1'b0);
    run("xor",  XOR_, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'h0FF0_0FF0, '0, 1'b0, 1'b0);
    run("slt_s", SLT, 1'b1, 32'hFFFF_FFFF, 32'h1, 0, 32'h1, '0, 1'b0, 1'b0);
    run("slt_u", SLT, 1'b0, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, '0, 1'b0, 1'b0);

    // MUL/DIV: out_valid in cycle accept+34, i.e. 33 edges after the accept edge
    run("mul_s_neg", MUL, 1'b1, 32'hFFFF_FFFD, 32'h5,         33, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run("mul_u_max", MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run("mul_s_pos", MUL, 1'b1, 32'h7,         32'h6,         33, 32'h2A,        32'h0,         1'b0, 1'b0);
    run("div_s_neg", DIV, 1'b1, 32'hFFFF_FFF9, 32'h2,         33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run("div_s_rn",  DIV, 1'b1, 32'h7,         32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'h1,         1'b0, 1'b0);
    run("div_u",     DIV, 1'b0, 32'hFFFF_FFFF, 32'h10,        33, 32'h0FFF_FFFF, 32'hF,         1'b0, 1'b0);
    run("div_zero",  DIV, 1'b1, 32'hFFFF_FFF9, 32'h0,         33, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 1'b1);
    run("div_minm1", DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0,         1'b1, 1'b0);

    // backpressure: result held 5 cycles, a new request in DONE must be ignored
    A = 32'hFFFF_FFFD; B = 32'h5; Op = MUL; Sign = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 32'h1; B = 32'h1; Op = ADD;
    for (int i = 0; i < 60 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("bp.valid0", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.valid", out_valid, 1'b1);
      chk("bp.in_ready", in_ready, 1'b0);
      chk("bp.z", {Z_hi, Z}, 64'hFFFF_FFFF_FFFF_FFF1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.drop", out_valid, 1'b0);
    chk("bp.idle", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bp.no_accept", out_valid, 1'b0);

    // reset during CALC aborts the operation
    A = 32'h3; B = 32'h3; Op = MUL; Sign = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort.busy", in_ready, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort.in_ready", in_ready, 1'b1);
    chk("abort.out_valid", out_valid, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort.no_result", out_valid, 1'b0);
    run("post_rst", ADD, 1'b0, 32'h2, 32'h3, 0, 32'h5, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
